// File: rtl/pint_pkg.sv
// Shared types and defaults for the PINT target-side interface.
package pint_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SHIFT,
        ST_WR_COMMIT,
        ST_RD_ADDR,
        ST_RD_FETCH,
        ST_RD_SHIFT
    } pint_state_e;

    localparam int unsigned PINT_ADDR_W      = 8;
    localparam int unsigned PINT_DATA_W      = 32;
    localparam int unsigned PINT_SYNC_STAGES = 2;
    localparam int unsigned PINT_RD_TIMEOUT  = 255;

    // Fill bit for the word returned when the register port never answers.
    localparam logic PINT_RD_TMO_BIT = 1'b1;

endpackage

// File: rtl/pint_sync_edge.sv
// Multi-flop synchronizer for the PINT inputs; the shift clock also gets a
// rising-edge detect. STAGES must be at least 2.
module pint_sync_edge #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_d_i,
    input  logic [WIDTH-1:0] data_d_i,
    output logic             rise_o,
    output logic [WIDTH-1:0] data_q_o
);

    logic [STAGES-1:0]            clk_sync_q;
    logic [STAGES-1:0][WIDTH-1:0] dat_sync_q;
    logic                         clk_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[STAGES-2:0], clk_d_i};
            dat_sync_q <= {dat_sync_q[STAGES-2:0], data_d_i};
            clk_prev_q <= clk_sync_q[STAGES-1];
        end
    end

    // Data and clock share the same depth, so data is sampled alongside the rise.
    assign rise_o   = clk_sync_q[STAGES-1] & ~clk_prev_q;
    assign data_q_o = dat_sync_q[STAGES-1];

endmodule

// File: rtl/pint_slave.sv
// PINT target: deserializes write frames into register strobes and serves
// read frames by fetching a register word and shifting it back MSB first.
//   state        | meaning
//   ST_IDLE      | waiting for a frame start (or for both requests low after a clash)
//   ST_WR_SHIFT  | collecting address+data bits of a write
//   ST_WR_COMMIT | write strobe issued, waiting for WRREQ to drop
//   ST_RD_ADDR   | collecting address bits of a read
//   ST_RD_FETCH  | read strobe issued, waiting for data or timeout
//   ST_RD_SHIFT  | shifting read data out, then waiting for RDREQ to drop
module pint_slave
    import pint_pkg::*;
#(
    parameter int unsigned ADDR_W      = PINT_ADDR_W,
    parameter int unsigned DATA_W      = PINT_DATA_W,
    parameter int unsigned SYNC_STAGES = PINT_SYNC_STAGES,
    parameter int unsigned RD_TIMEOUT  = PINT_RD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PINT_CLK,
    input  logic              PINT_RESETN,
    input  logic              PINT_WRREQ,
    input  logic              PINT_RDREQ,
    input  logic              PINT_WRDATA,
    output logic              PINT_RDRDY,
    output logic              PINT_RDDATA,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    input  logic              reg_rd_valid,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned TMO_W   = $clog2(RD_TIMEOUT + 1);

    logic [3:0] sync_s;
    logic       pclk_rise;
    logic       resetn_s, rdreq_s, wrreq_s, wrdata_s;

    pint_sync_edge #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (4)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .clk_d_i  (PINT_CLK),
        .data_d_i ({PINT_RESETN, PINT_RDREQ, PINT_WRREQ, PINT_WRDATA}),
        .rise_o   (pclk_rise),
        .data_q_o (sync_s)
    );

    assign {resetn_s, rdreq_s, wrreq_s, wrdata_s} = sync_s;

    pint_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d, frame_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DATA_W-1:0]  rd_shift_q, rd_shift_d;
    logic               rdrdy_q, rdrdy_d;
    logic               block_q, block_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]  reg_wr_data_q, reg_wr_data_d;
    logic               reg_wr_en_q, reg_wr_en_d;
    logic               reg_rd_en_q, reg_rd_en_d;
    logic               proto_err_q, proto_err_d;

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        rd_shift_d    = rd_shift_q;
        rdrdy_d       = rdrdy_q;
        block_d       = block_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_en_d   = 1'b0;
        reg_rd_en_d   = 1'b0;
        proto_err_d   = 1'b0;
        frame_nxt     = {frame_q[FRAME_W-2:0], wrdata_s};

        unique case (state_q)
            ST_IDLE: begin
                if (pclk_rise) begin
                    if (block_q) begin
                        block_d = wrreq_s | rdreq_s;
                    end else if (wrreq_s && rdreq_s) begin
                        proto_err_d = 1'b1;
                        block_d     = 1'b1;
                    end else if (wrreq_s || rdreq_s) begin
                        frame_d = {{(FRAME_W-1){1'b0}}, wrdata_s};
                        cnt_d   = CNT_W'(1);
                        state_d = wrreq_s ? ST_WR_SHIFT : ST_RD_ADDR;
                    end
                end
            end
            ST_WR_SHIFT: begin
                if (pclk_rise) begin
                    if (!wrreq_s) begin
                        proto_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_d = frame_nxt;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            reg_addr_d    = frame_nxt[FRAME_W-1 -: ADDR_W];
                            reg_wr_data_d = frame_nxt[DATA_W-1:0];
                            reg_wr_en_d   = 1'b1;
                            state_d       = ST_WR_COMMIT;
                        end
                    end
                end
            end
            ST_WR_COMMIT: begin
                if (pclk_rise && !wrreq_s) state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (pclk_rise) begin
                    if (!rdreq_s) begin
                        proto_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_d = frame_nxt;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            reg_addr_d  = frame_nxt[ADDR_W-1:0];
                            reg_rd_en_d = 1'b1;
                            tmo_d       = TMO_W'(RD_TIMEOUT);
                            state_d     = ST_RD_FETCH;
                        end
                    end
                end
            end
            ST_RD_FETCH: begin
                // A valid arriving on the terminal-count cycle still wins.
                if (reg_rd_valid || tmo_q == TMO_W'(1)) begin
                    rd_shift_d  = reg_rd_valid ? reg_rd_data : {DATA_W{PINT_RD_TMO_BIT}};
                    proto_err_d = ~reg_rd_valid;
                    rdrdy_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RD_SHIFT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_RD_SHIFT: begin
                if (pclk_rise) begin
                    if (rdrdy_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            rdrdy_d    = 1'b0;
                            rd_shift_d = '0;
                        end else begin
                            rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
                        end
                    end else if (!rdreq_s) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!resetn_s) begin
            state_d       = ST_IDLE;
            frame_d       = '0;
            cnt_d         = '0;
            tmo_d         = '0;
            rd_shift_d    = '0;
            rdrdy_d       = 1'b0;
            block_d       = 1'b0;
            reg_addr_d    = '0;
            reg_wr_data_d = '0;
            reg_wr_en_d   = 1'b0;
            reg_rd_en_d   = 1'b0;
            proto_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            frame_q       <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            rd_shift_q    <= '0;
            rdrdy_q       <= 1'b0;
            block_q       <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_rd_en_q   <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            rd_shift_q    <= rd_shift_d;
            rdrdy_q       <= rdrdy_d;
            block_q       <= block_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_rd_en_q   <= reg_rd_en_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign PINT_RDRDY  = rdrdy_q;
    assign PINT_RDDATA = rd_shift_q[DATA_W-1];
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign proto_err   = proto_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pint_slave.sv
// Self-checking bench for pint_slave: acts as PINT initiator and register
// peripheral, compares against a simple register-memory reference model.
module tb_pint_slave;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          PINT_CLK = 1'b0, PINT_RESETN = 1'b1;
    logic          PINT_WRREQ = 1'b0, PINT_RDREQ = 1'b0, PINT_WRDATA = 1'b0;
    logic          PINT_RDRDY, PINT_RDDATA;
    logic [AW-1:0] reg_addr;
    logic          reg_wr_en, reg_rd_en, reg_rd_valid, busy, proto_err;
    logic [DW-1:0] reg_wr_data, reg_rd_data;

    pint_slave dut (
        .clk          (clk),
        .reset        (reset),
        .PINT_CLK     (PINT_CLK),
        .PINT_RESETN  (PINT_RESETN),
        .PINT_WRREQ   (PINT_WRREQ),
        .PINT_RDREQ   (PINT_RDREQ),
        .PINT_WRDATA  (PINT_WRDATA),
        .PINT_RDRDY   (PINT_RDRDY),
        .PINT_RDDATA  (PINT_RDDATA),
        .reg_addr     (reg_addr),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Peripheral register file (served to the DUT) and reference expectation.
    logic [DW-1:0] dut_regs [256];
    logic [DW-1:0] ref_mem  [256];

    int            cyc = 0, wr_cnt = 0, rd_cnt = 0, perr_cnt = 0;
    int            rden_cyc = 0, perr_cyc = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;
    int            rd_lat = 0;

    always @(negedge clk) begin
        cyc++;
        if (reg_wr_en) begin
            wr_cnt++;
            last_wr_addr = reg_addr;
            last_wr_data = reg_wr_data;
            dut_regs[reg_addr] = reg_wr_data;
        end
        if (reg_rd_en) begin
            rd_cnt++;
            rden_cyc = cyc;
        end
        if (proto_err) begin
            perr_cnt++;
            perr_cyc = cyc;
        end
    end

    // Register-port responder; rd_lat < 0 means never answer.
    initial begin
        reg_rd_valid = 1'b0;
        reg_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (reg_rd_en && rd_lat >= 0) begin
                repeat (rd_lat) @(negedge clk);
                reg_rd_data  = dut_regs[reg_addr];
                reg_rd_valid = 1'b1;
                @(negedge clk);
                reg_rd_valid = 1'b0;
                reg_rd_data  = $urandom;
            end
        end
    end

    // One PINT_CLK period (clk/8): change lines while low, then rise, then fall.
    task automatic pint_bit(input logic wr, input logic rd, input logic d);
        PINT_WRREQ  = wr;
        PINT_RDREQ  = rd;
        PINT_WRDATA = d;
        repeat (4) @(negedge clk);
        PINT_CLK = 1'b1;
        repeat (4) @(negedge clk);
        PINT_CLK = 1'b0;
    endtask

    task automatic pint_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int abort_at, input int rst_at);
        logic [AW+DW-1:0] fr;
        int w0, p0, nbits;
        fr = {a, d};
        w0 = wr_cnt;
        p0 = perr_cnt;
        nbits = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : AW + DW);
        for (int i = 0; i < nbits; i++) pint_bit(1'b1, 1'b0, fr[AW+DW-1-i]);
        if (rst_at >= 0) begin
            reset = 1'b1;
            #1;
            chk("arst_busy", busy, 0);
            chk("arst_addr", reg_addr, 0);
            chk("arst_wdata", reg_wr_data, 0);
            @(negedge clk);
            PINT_WRREQ = 1'b0;
            reset = 1'b0;
            repeat (6) @(negedge clk);
            chk("arst_no_wr", wr_cnt, w0);
            chk("arst_idle", busy, 0);
            return;
        end
        pint_bit(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        if (abort_at >= 0) begin
            chk("abort_no_wr", wr_cnt, w0);
            chk("abort_perr", perr_cnt, p0 + 1);
            chk("abort_idle", busy, 0);
        end else begin
            chk("wr_count", wr_cnt, w0 + 1);
            chk("wr_addr", last_wr_addr, a);
            chk("wr_data", last_wr_data, d);
            chk("wr_no_perr", perr_cnt, p0);
            chk("wr_idle", busy, 0);
            ref_mem[a] = d;
        end
    endtask

    task automatic pint_read(input logic [AW-1:0] a, input int lat, input int rstn_at);
        logic [DW-1:0] got, exp;
        int r0, p0, w0;
        bit ok;
        r0 = rd_cnt;
        p0 = perr_cnt;
        w0 = wr_cnt;
        rd_lat = lat;
        exp = (lat < 0) ? '1 : ref_mem[a];
        for (int i = 0; i < AW; i++) pint_bit(1'b0, 1'b1, a[AW-1-i]);
        repeat (4) @(negedge clk);
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = PINT_RDRDY;
        end
        chk("rdrdy_rise", ok, 1);
        if (!ok) begin
            pint_bit(1'b0, 1'b0, 1'b0);
            return;
        end
        repeat (4) @(negedge clk);
        got = '0;
        for (int i = 0; i < DW; i++) begin
            if (i == rstn_at) begin
                PINT_RESETN = 1'b0;
                repeat (4) @(negedge clk);
                chk("rstn_rdrdy", PINT_RDRDY, 0);
                chk("rstn_busy", busy, 0);
                chk("rstn_addr", reg_addr, 0);
                chk("rstn_no_perr", perr_cnt, p0);
                PINT_RDREQ  = 1'b0;
                PINT_RESETN = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            if (i == DW - 1) chk("rdrdy_hold", PINT_RDRDY, 1);
            got = {got[DW-2:0], PINT_RDDATA};
            PINT_CLK = 1'b1;
            repeat (4) @(negedge clk);
            PINT_CLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("rdrdy_fall", PINT_RDRDY, 0);
        chk("rd_data", got, exp);
        chk("rd_en_count", rd_cnt, r0 + 1);
        chk("rd_perr", perr_cnt, p0 + ((lat < 0) ? 1 : 0));
        chk("rd_no_wr", wr_cnt, w0);
        if (lat < 0) chk("tmo_latency", perr_cyc - rden_cyc, 255);
        pint_bit(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("rd_idle", busy, 0);
    endtask

    initial begin
        int p0, w0, r0;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        for (int i = 0; i < 256; i++) begin
            rd = $urandom;
            dut_regs[i] = rd;
            ref_mem[i]  = rd;
        end
        dut_regs[8'h12] = 32'h8000_0001;
        ref_mem[8'h12]  = 32'h8000_0001;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdrdy", PINT_RDRDY, 0);
        chk("rst_rddata", PINT_RDDATA, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wr_data, 0);
        chk("rst_strobes", {reg_wr_en, reg_rd_en, proto_err}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        pint_write(8'h3C, 32'hA5A5_0F0F, -1, -1);
        pint_read(8'h12, 3, -1);
        pint_write(8'h77, 32'h1234_5678, 20, -1);
        pint_write(8'h01, 32'h0000_0002, -1, -1);
        pint_read(8'h01, -1, -1);
        pint_read(8'h01, 0, -1);

        p0 = perr_cnt; w0 = wr_cnt; r0 = rd_cnt;
        pint_bit(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("clash_idle", busy, 0);
        pint_bit(1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("clash_blocked", busy, 0);
        pint_bit(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("clash_perr", perr_cnt, p0 + 1);
        chk("clash_no_strobe", wr_cnt + rd_cnt, w0 + r0);
        pint_write(8'hC3, 32'hDEAD_BEEF, -1, -1);

        pint_read(8'h3C, 1, 10);
        pint_read(8'h3C, 2, -1);
        pint_write(8'h55, 32'h0BAD_F00D, -1, 15);
        pint_write(8'h55, 32'h600D_CAFE, -1, -1);
        pint_read(8'h55, 5, -1);

        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                pint_write(ra, $urandom, -1, -1);
            end else begin
                pint_read(ra, ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8)), -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pint_slave.md
Name: pint_slave

Overview:
- Target-side (chip/emulated-target) end of the PINT serial interface that the ICE controller drives as initiator.
- Oversamples PINT_CLK, PINT_WRREQ, PINT_RDREQ, PINT_WRDATA and PINT_RESETN in the local clock domain and deserializes write frames into local register writes.
- Serves read requests by fetching from a local register port and shifting the result back on PINT_RDDATA with PINT_RDRDY.

Parameters:
- ADDR_W, 8, address bits per frame.
- DATA_W, 32, data bits per frame.
- SYNC_STAGES, 2, flip-flop stages on every PINT input.
- RD_TIMEOUT, 255, clk cycles to wait for reg_rd_valid before returning all-ones.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- PINT_CLK  in  1  initiator shift clock; asynchronous to clk.
- PINT_RESETN  in  1  active-low protocol reset from the initiator.
- PINT_WRREQ  in  1  write frame enable.
- PINT_RDREQ  in  1  read frame enable.
- PINT_WRDATA  in  1  serial address/data from the initiator, MSB first.
- PINT_RDRDY  out  1  read data valid; high for the whole shift-out.
- PINT_RDDATA  out  1  serial read data, MSB first.
- reg_addr  out  ADDR_W  local register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  DATA_W  write data; valid with reg_wr_en.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  DATA_W  read data; valid with reg_rd_valid.
- reg_rd_valid  in  1  read data ready; any latency of 0 or more cycles after reg_rd_en.
- busy  out  1  FSM not in IDLE.
- proto_err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; shift registers 0.
- Synchronized PINT_RESETN low forces IDLE and the reset values of all outputs except proto_err. It does not pulse proto_err.
- Input sync: all PINT inputs pass through SYNC_STAGES flops.
- Edge detect: rise = sync PINT_CLK high and previous sample low. All PINT timing below refers to detected rises.
- PINT_CLK high and low times must each be at least SYNC_STAGES+1 clk cycles. Shorter pulses are out of spec.
- WRREQ/RDREQ/WRDATA are sampled at each detected rise. The initiator changes them on falling edges.
- IDLE:
  - rise with WRREQ=1, RDREQ=0: capture the first address bit and go to WR_SHIFT.
  - rise with RDREQ=1, WRREQ=0: capture the first address bit and go to RD_ADDR.
  - rise with both high: pulse proto_err and stay in IDLE until both are low at a rise.
- WR_SHIFT: shift one bit per rise, ADDR_W+DATA_W bits total.
  - WRREQ=0 at a rise before the count completes: abort, pulse proto_err, go to IDLE, no register write.
  - On the final bit go to WR_COMMIT.
- WR_COMMIT:
  - One cycle: reg_addr and reg_wr_data take the frame and reg_wr_en=1. reg_addr and reg_wr_data hold until the next frame.
  - Then wait for a rise with WRREQ=0. Rises with WRREQ still high are ignored. Then go to IDLE.
- RD_ADDR: shift ADDR_W bits.
  - RDREQ=0 at a rise before completion: abort, pulse proto_err, go to IDLE.
  - On completion go to RD_FETCH.
- RD_FETCH:
  - reg_rd_en pulses in the first cycle and the timeout counter starts.
  - reg_rd_valid latches reg_rd_data into the output shift register.
  - A timeout after RD_TIMEOUT cycles loads all-ones and pulses proto_err.
  - reg_rd_valid in the same cycle as the timeout wins.
  - Go to RD_SHIFT.
- RD_SHIFT:
  - PINT_RDRDY=1 and PINT_RDDATA=bit DATA_W-1 on entry.
  - Each rise advances one bit (the initiator samples on rise, then the slave updates).
  - After the DATA_W-th rise, PINT_RDRDY=0 and PINT_RDDATA=0, then wait for a rise with RDREQ=0 and go to IDLE.
  - Rises occurring during RD_FETCH are ignored. The initiator waits for PINT_RDRDY.
- Mid-operation reset (async reset or PINT_RESETN): abandon the frame with no register strobe.
- busy = (state != IDLE).

Decomposition:
- Package pint_pkg: state enum (IDLE, WR_SHIFT, WR_COMMIT, RD_ADDR, RD_FETCH, RD_SHIFT), default widths, timeout read value.
- Sub-module pint_sync_edge: N-stage synchronizer with rise detect. Instanced for PINT_CLK; plain sync for the other inputs.

Test Plan:
- Write frame addr 0x3C, data 0xA5A5_0F0F with PINT_CLK at clk/8:
  - exactly one reg_wr_en with reg_addr=0x3C, reg_wr_data=0xA5A50F0F;
  - busy returns to 0 after WRREQ drops.
- Read addr 0x12 with reg_rd_valid 3 cycles after reg_rd_en, reg_rd_data=0x8000_0001:
  - PINT_RDRDY rises;
  - bits sampled on 32 rises equal 0x80000001;
  - PINT_RDRDY falls after the 32nd rise.
- Write aborted (WRREQ low after 20 bits):
  - one proto_err pulse, no reg_wr_en, IDLE.
  - A following good write of 0x01/0x00000002 succeeds.
- Read with reg_rd_valid never asserted:
  - proto_err after 255 cycles, 32 ones returned.
- WRREQ and RDREQ both high at first rise:
  - proto_err, no strobes, remains IDLE.
- PINT_RESETN low mid-read (during RD_SHIFT) and async reset mid-write:
  - outputs return to 0 immediately, no strobe;
  - the next frame completes normally.
